// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port plus the instruction-register handshake toward decode.
// The fetch unit takes the master side; memory and consumer take the slave side.
interface instruction_fetch_unit_if;
  logic [7:0]  inst_address;
  logic [31:0] read_data;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  pc_out;

  modport master (
    output inst_address,
    output ir_out,
    output ir_valid,
    output pc_out,
    input  read_data,
    input  ir_ready,
    input  branch_taken,
    input  branch_target
  );

  modport slave (
    input  inst_address,
    input  ir_out,
    input  ir_valid,
    input  pc_out,
    output read_data,
    output ir_ready,
    output branch_taken,
    output branch_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC, captures memory words into the IR and hands them to decode
// over valid/ready. Handles sequential advance, taken branches and a halting opcode.
module instruction_fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'd2,
  parameter logic [2:0]  HALT_OP  = 3'b111,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  instruction_fetch_unit_if.master bus,
  output logic                    halted,
  output logic [CNT_W-1:0]        fetch_count
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StValid,
    StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [7:0]       pc_out_q, pc_out_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      pc_out_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    count_d  = count_q;
    accept   = (state_q == StValid) && bus.ir_ready;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        ir_d     = bus.read_data;
        pc_out_d = pc_q;
        if (count_q != '1) count_d = count_q + CNT_W'(1);
        state_d  = StValid;
      end
      StValid: begin
        if (accept) begin
          // The PC moves even on a halting accept so a later observer sees the redirect.
          pc_d    = bus.branch_taken ? bus.branch_target : pc_q + 8'd1;
          state_d = (ir_q[31:29] == HALT_OP) ? StHalt : StFetch;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.inst_address = pc_q;
  assign bus.ir_out       = ir_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.ir_valid     = (state_q == StValid);
  assign halted           = (state_q == StHalt);
  assign fetch_count      = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: each accepted instruction pushes the next expected {pc, word};
// each new ir_valid pops and compares.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halted;
  logic [15:0] fetch_count;

  instruction_fetch_unit_if bus ();

  logic [31:0] ram [256];

  assign bus.read_data = ram[bus.inst_address];

  instruction_fetch_unit #(
    .RESET_PC (8'd2),
    .HALT_OP  (3'b111),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [39:0] sb [$];
  logic [7:0]  exp_pc;
  int          exp_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    while (!bus.ir_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ir_valid) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic push_exp(input logic [7:0] pc);
    sb.push_back({pc, ram[pc]});
    exp_cnt++;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_pc  = 8'd2;
    exp_cnt = 0;
  endtask

  task automatic start_run();
    start = 1'b1;
    push_exp(exp_pc);
    @(negedge clk);
    start = 1'b0;
    check("fetch_not_valid", {63'd0, bus.ir_valid}, 64'd0);
  endtask

  // Accept one instruction after 'stall' cycles of ir_ready=0 with branch noise.
  task automatic take(input int stall, input logic br, input logic [7:0] tgt, input int exp_wait);
    int          waited;
    logic [39:0] e;
    logic [7:0]  next;
    logic        is_halt;
    wait_valid(waited);
    if (exp_wait >= 0) check("latency", 64'(waited), 64'(exp_wait));
    check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("ir_out", 64'(bus.ir_out), 64'(e[31:0]));
    check("pc_out", 64'(bus.pc_out), 64'(e[39:32]));
    check("fetch_count", 64'(fetch_count), 64'(exp_cnt));
    for (int i = 0; i < stall; i++) begin
      bus.ir_ready      = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_target = ~tgt;
      @(negedge clk);
      check("stall_valid", {63'd0, bus.ir_valid}, 64'd1);
      check("stall_ir", 64'(bus.ir_out), 64'(e[31:0]));
      check("stall_pc_out", 64'(bus.pc_out), 64'(e[39:32]));
      check("stall_addr", 64'(bus.inst_address), 64'(exp_pc));
    end
    bus.ir_ready      = 1'b1;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    next    = br ? tgt : exp_pc + 8'd1;
    is_halt = (e[31:29] == 3'b111);
    exp_pc  = next;
    if (!is_halt) push_exp(next);
    @(negedge clk);
    bus.ir_ready     = 1'b0;
    bus.branch_taken = 1'b0;
    check("valid_drop", {63'd0, bus.ir_valid}, 64'd0);
    check("halted", {63'd0, halted}, {63'd0, is_halt});
    check("addr_after_accept", 64'(bus.inst_address), 64'(next));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'(i);
    ram[5] = 32'hE000_0000;
    bus.ir_ready      = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'd0;

    // Reset state, then idle with start low.
    do_reset(2);
    check("rst_addr", 64'(bus.inst_address), 64'd2);
    check("rst_valid", {63'd0, bus.ir_valid}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_ir", 64'(bus.ir_out), 64'd0);
    check("rst_pc_out", 64'(bus.pc_out), 64'd0);
    repeat (5) @(negedge clk);
    check("idle_addr", 64'(bus.inst_address), 64'd2);
    check("idle_valid", {63'd0, bus.ir_valid}, 64'd0);
    check("idle_count", 64'(fetch_count), 64'd0);

    // Run A: stall, sequential, branches, wrap, halt with branch.
    start_run();
    take(4, 1'b0, 8'd0, 1);     // 2, stalled
    take(0, 1'b0, 8'd0, 1);     // 3
    take(0, 1'b1, 8'd9, 1);     // 4 -> branch to 9
    take(0, 1'b1, 8'd4, 1);     // 9 -> branch to 4
    take(2, 1'b1, 8'd255, 1);   // 4, branch noise while stalled -> 255
    take(0, 1'b0, 8'd0, 1);     // 255 -> wraps to 0
    take(0, 1'b1, 8'd0, 1);     // 0 -> branch to itself
    take(0, 1'b1, 8'd5, 1);     // 0 -> 5
    take(0, 1'b1, 8'd7, 1);     // 5 is HALT, branch still moves the PC
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("haltA_halted", {63'd0, halted}, 64'd1);
    check("haltA_valid", {63'd0, bus.ir_valid}, 64'd0);
    check("haltA_addr", 64'(bus.inst_address), 64'd7);

    // Run B: sequential fetch into the HALT word.
    do_reset(1);
    check("rstB_halted", {63'd0, halted}, 64'd0);
    check("rstB_addr", 64'(bus.inst_address), 64'd2);
    start_run();
    take(0, 1'b0, 8'd0, 1);     // 2
    take(0, 1'b0, 8'd0, 1);     // 3
    take(0, 1'b0, 8'd0, 1);     // 4
    take(0, 1'b0, 8'd0, 1);     // 5 HALT
    repeat (6) @(negedge clk);
    check("haltB_halted", {63'd0, halted}, 64'd1);
    check("haltB_valid", {63'd0, bus.ir_valid}, 64'd0);
    check("haltB_addr", 64'(bus.inst_address), 64'd6);
    check("haltB_count", 64'(fetch_count), 64'd4);

    // Run C: reset while VALID discards the IR and returns to IDLE.
    do_reset(1);
    start_run();
    begin
      int w;
      wait_valid(w);
      check("C_latency", 64'(w), 64'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_pc  = 8'd2;
    exp_cnt = 0;
    check("C_valid", {63'd0, bus.ir_valid}, 64'd0);
    check("C_addr", 64'(bus.inst_address), 64'd2);
    check("C_ir", 64'(bus.ir_out), 64'd0);
    check("C_count", 64'(fetch_count), 64'd0);
    repeat (3) @(negedge clk);
    check("C_idle_valid", {63'd0, bus.ir_valid}, 64'd0);
    start_run();
    take(0, 1'b0, 8'd0, 1);     // 2 again after restart

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
